// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bit positions inside the EXE->MEM
// memory-control bundle, bundle widths, and field positions used to build
// the forwarding bus.
package mem_stage_pkg;

  // exe_mem_all bit positions: {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
  localparam int MA_W     = 8;
  localparam int MA_WE    = 7;
  localparam int MA_LD_B  = 6;
  localparam int MA_LD_H  = 5;
  localparam int MA_LD_W  = 4;
  localparam int MA_LD_SE = 3;
  localparam int MA_ST_B  = 2;
  localparam int MA_ST_H  = 1;
  localparam int MA_ST_W  = 0;

  // Bundle widths
  localparam int RF_W  = 6;
  localparam int CSR_W = 79;
  localparam int EXC_W = 2;
  localparam int FWD_W = 53;

  // Exception bundle bit positions
  localparam int EXC_SYSCALL = 1;
  localparam int EXC_ERTN    = 0;

  // CSR bundle: {csr_rd, csr_wr, csr_wr_num[13:0], ...}
  localparam int CSR_RD_BIT = 78;
  localparam int CSR_WR_BIT = 77;
  localparam int CSR_NUM_HI = 76;
  localparam int CSR_NUM_LO = 63;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension.
// Ports:
//   rdata_i  : raw 32-bit word returned by the data SRAM
//   addr_i   : low two bits of the load address
//   ld_b_i   : byte load
//   ld_h_i   : halfword load
//   ld_w_i   : word load
//   ld_se_i  : sign-extend (otherwise zero-extend)
//   value_o  : aligned, extended 32-bit load value
module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic        ld_b_i,
  input  logic        ld_h_i,
  input  logic        ld_w_i,
  input  logic        ld_se_i,
  output logic [31:0] value_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata_i[7:0];
    case (addr_i)
      2'd0:    sel_byte = rdata_i[7:0];
      2'd1:    sel_byte = rdata_i[15:8];
      2'd2:    sel_byte = rdata_i[23:16];
      default: sel_byte = rdata_i[31:24];
    endcase
    sel_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    value_o = rdata_i;
    if (ld_b_i) begin
      value_o = {{24{ld_se_i & sel_byte[7]}}, sel_byte};
    end else if (ld_h_i) begin
      value_o = {{16{ld_se_i & sel_half[15]}}, sel_half};
    end else if (ld_w_i) begin
      value_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline.
// Issues the data-SRAM request on the EXE->MEM handoff cycle, holds the EXE
// payload, aligns/extends returned load data, drives the MEM forwarding bus
// and hands result, CSR and exception bundles to WB.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   exe_to_mem_valid/mem_allowin : EXE->MEM handshake
//   exe_*                    : EXE payload (pc, result/address, load flag,
//                              memory control, store data, rf/csr/exc bundles)
//   wb_exc_pending           : WB holds a syscall/ertn, suppress memory access
//   cancel_exc_ertn          : pipeline flush
//   wb_allowin/mem_to_wb_valid : MEM->WB handshake
//   mem_*                    : latched payload / final result to WB
//   mem_fwd_all              : {csr_wr, csr_wr_num, rf_we, rf_waddr, mem_result}
//   data_sram_*              : synchronous data SRAM interface
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               exe_to_mem_valid,
  output logic               mem_allowin,
  input  logic [31:0]        exe_pc,
  input  logic [31:0]        exe_result,
  input  logic               exe_res_from_mem,
  input  logic [MA_W-1:0]    exe_mem_all,
  input  logic [31:0]        exe_rkd_value,
  input  logic [RF_W-1:0]    exe_rf_all,
  input  logic [CSR_W-1:0]   exe_csr_rf,
  input  logic [EXC_W-1:0]   exe_exc_rf,
  input  logic               wb_exc_pending,
  input  logic               cancel_exc_ertn,
  input  logic               wb_allowin,
  output logic               mem_to_wb_valid,
  output logic [31:0]        mem_pc,
  output logic [31:0]        mem_result,
  output logic [RF_W-1:0]    mem_rf_all,
  output logic [CSR_W-1:0]   mem_csr_rf,
  output logic [EXC_W-1:0]   mem_exc_rf,
  output logic [FWD_W-1:0]   mem_fwd_all,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  input  logic [31:0]        data_sram_rdata
);

  logic             mem_valid_q, mem_valid_d;
  logic             rdata_vld_q;
  logic [31:0]      rdata_hold_q;
  logic [31:0]      pc_q;
  logic [31:0]      result_q;
  logic             res_from_mem_q;
  logic [3:0]       ld_q;            // {ld_b, ld_h, ld_w, ld_se}
  logic [RF_W-1:0]  rf_all_q;
  logic [CSR_W-1:0] csr_rf_q;
  logic [EXC_W-1:0] exc_rf_q;

  logic        load_en;
  logic        go;
  logic        kill;
  logic        exe_mem_we;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] load_rdata;
  logic [31:0] load_value;

  // ready_go is always 1: the SRAM answers in exactly one cycle
  assign mem_allowin     = ~mem_valid_q | wb_allowin | cancel_exc_ertn;
  assign mem_to_wb_valid = mem_valid_q;
  assign load_en         = exe_to_mem_valid & mem_allowin;

  always_comb begin
    mem_valid_d = mem_valid_q;
    if (cancel_exc_ertn) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = exe_to_mem_valid;
    end
  end

  // Request qualification: any exception in flight (EXE, MEM or WB) suppresses
  // the access so a store behind a syscall/ertn never reaches memory.
  assign exe_mem_we = exe_mem_all[MA_WE];
  assign go         = exe_to_mem_valid & mem_allowin & ~cancel_exc_ertn;
  assign kill       = (|exe_exc_rf) | (mem_valid_q & (|exc_rf_q)) | wb_exc_pending;

  always_comb begin
    st_we    = 4'b0000;
    st_wdata = exe_rkd_value;
    if (exe_mem_all[MA_ST_B]) begin
      st_we    = 4'b0001 << exe_result[1:0];
      st_wdata = {4{exe_rkd_value[7:0]}};
    end else if (exe_mem_all[MA_ST_H]) begin
      st_we    = exe_result[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{exe_rkd_value[15:0]}};
    end else if (exe_mem_all[MA_ST_W]) begin
      st_we    = 4'b1111;
      st_wdata = exe_rkd_value;
    end
  end

  assign data_sram_en    = go & ~kill & (exe_res_from_mem | exe_mem_we);
  assign data_sram_we    = (data_sram_en & exe_mem_we) ? st_we : 4'b0000;
  assign data_sram_addr  = exe_result;
  assign data_sram_wdata = st_wdata;

  // ---- EXE -> MEM pipeline register ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      rdata_vld_q    <= 1'b0;
      pc_q           <= '0;
      result_q       <= '0;
      res_from_mem_q <= 1'b0;
      ld_q           <= '0;
      rf_all_q       <= '0;
      csr_rf_q       <= '0;
      exc_rf_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      // SRAM data is only live in the cycle right after the request
      rdata_vld_q <= data_sram_en;
      if (load_en) begin
        pc_q           <= exe_pc;
        result_q       <= exe_result;
        res_from_mem_q <= exe_res_from_mem;
        ld_q           <= {exe_mem_all[MA_LD_B], exe_mem_all[MA_LD_H],
                           exe_mem_all[MA_LD_W], exe_mem_all[MA_LD_SE]};
        rf_all_q       <= exe_rf_all;
        csr_rf_q       <= exe_csr_rf;
        exc_rf_q       <= exe_exc_rf;
      end
    end
  end

  // Capture the SRAM word on the first MEM cycle so a WB stall sees stable
  // load data even though the SRAM output may change afterwards.
  always_ff @(posedge clk) begin
    if (rdata_vld_q) begin
      rdata_hold_q <= data_sram_rdata;
    end
  end

  assign load_rdata = rdata_vld_q ? data_sram_rdata : rdata_hold_q;

  mem_load_align u_load_align (
    .rdata_i (load_rdata),
    .addr_i  (result_q[1:0]),
    .ld_b_i  (ld_q[3]),
    .ld_h_i  (ld_q[2]),
    .ld_w_i  (ld_q[1]),
    .ld_se_i (ld_q[0]),
    .value_o (load_value)
  );

  assign mem_result = res_from_mem_q ? load_value : result_q;
  assign mem_pc     = pc_q;
  assign mem_rf_all = rf_all_q;
  assign mem_csr_rf = csr_rf_q;
  assign mem_exc_rf = exc_rf_q;

  // Write enables are gated by valid so a bubble never forwards
  assign mem_fwd_all = {csr_rf_q[CSR_WR_BIT] & mem_valid_q,
                        csr_rf_q[CSR_NUM_HI:CSR_NUM_LO],
                        rf_all_q[RF_W-1] & mem_valid_q,
                        rf_all_q[RF_W-2:0],
                        mem_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic        exe_res_from_mem;
  logic [7:0]  exe_mem_all;
  logic [31:0] exe_rkd_value;
  logic [5:0]  exe_rf_all;
  logic [78:0] exe_csr_rf;
  logic [1:0]  exe_exc_rf;
  logic        wb_exc_pending;
  logic        cancel_exc_ertn;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;
  logic [5:0]  mem_rf_all;
  logic [78:0] mem_csr_rf;
  logic [1:0]  mem_exc_rf;
  logic [52:0] mem_fwd_all;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allowin      (mem_allowin),
    .exe_pc           (exe_pc),
    .exe_result       (exe_result),
    .exe_res_from_mem (exe_res_from_mem),
    .exe_mem_all      (exe_mem_all),
    .exe_rkd_value    (exe_rkd_value),
    .exe_rf_all       (exe_rf_all),
    .exe_csr_rf       (exe_csr_rf),
    .exe_exc_rf       (exe_exc_rf),
    .wb_exc_pending   (wb_exc_pending),
    .cancel_exc_ertn  (cancel_exc_ertn),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_pc           (mem_pc),
    .mem_result       (mem_result),
    .mem_rf_all       (mem_rf_all),
    .mem_csr_rf       (mem_csr_rf),
    .mem_exc_rf       (mem_exc_rf),
    .mem_fwd_all      (mem_fwd_all),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count SRAM requests seen at the active edge
  always @(posedge clk) begin
    if (data_sram_en) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  mem_all;
    logic        res_mem;
    logic [31:0] addr;
    logic [31:0] rkd;
    logic [31:0] rdata;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // mem_all = {we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
    vecs[0]  = '{"st_b_a3",   8'b1000_0100, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1003};
    vecs[1]  = '{"ld_b_se",   8'b0100_1000, 1'b1, 32'h0000_1002, 32'h0,         32'h12F0_3456, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FFF0};
    vecs[2]  = '{"ld_bu",     8'b0100_0000, 1'b1, 32'h0000_1002, 32'h0,         32'h12F0_3456, 1'b1, 4'b0000, 32'h0,         32'h0000_00F0};
    vecs[3]  = '{"ld_hu_a2",  8'b0010_0000, 1'b1, 32'h0000_0002, 32'h0,         32'h8001_0000, 1'b1, 4'b0000, 32'h0,         32'h0000_8001};
    vecs[4]  = '{"ld_h_se",   8'b0010_1000, 1'b1, 32'h0000_0000, 32'h0,         32'h1234_8001, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8001};
    vecs[5]  = '{"st_h_a2",   8'b1000_0010, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0002};
    vecs[6]  = '{"st_w",      8'b1000_0001, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0040};
    vecs[7]  = '{"ld_w",      8'b0001_0000, 1'b1, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{"alu",       8'b0000_0000, 1'b0, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
    vecs[9]  = '{"st_b_a1",   8'b1000_0100, 1'b0, 32'h0000_0001, 32'h0000_007F, 32'h0,         1'b1, 4'b0010, 32'h7F7F_7F7F, 32'h0000_0001};
    vecs[10] = '{"ld_b_se_a3",8'b0100_1000, 1'b1, 32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80};

    resetn = 1'b0; exe_to_mem_valid = 1'b0; exe_pc = '0; exe_result = '0;
    exe_res_from_mem = 1'b0; exe_mem_all = '0; exe_rkd_value = '0; exe_rf_all = '0;
    exe_csr_rf = '0; exe_exc_rf = '0; wb_exc_pending = 1'b0; cancel_exc_ertn = 1'b0;
    wb_allowin = 1'b1; data_sram_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", mem_to_wb_valid, 0);
    chk("rst_fwd", mem_fwd_all, 0);
    chk("rst_allowin", mem_allowin, 1);
    chk("rst_pc", mem_pc, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven single instructions
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exe_to_mem_valid = 1'b1;
      exe_mem_all      = vecs[i].mem_all;
      exe_res_from_mem = vecs[i].res_mem;
      exe_result       = vecs[i].addr;
      exe_rkd_value    = vecs[i].rkd;
      exe_rf_all       = 6'b10_0001;
      exe_pc           = 32'h1c00_0000 + 32'(i * 4);
      #1;
      chk({vecs[i].name, "_en"},    data_sram_en,    vecs[i].exp_en);
      chk({vecs[i].name, "_we"},    data_sram_we,    vecs[i].exp_we);
      chk({vecs[i].name, "_wdata"}, data_sram_wdata, vecs[i].exp_wdata);
      chk({vecs[i].name, "_addr"},  data_sram_addr,  vecs[i].addr);
      @(negedge clk);
      exe_to_mem_valid = 1'b0;
      data_sram_rdata  = vecs[i].rdata;
      #1;
      chk({vecs[i].name, "_result"}, mem_result, vecs[i].exp_result);
      chk({vecs[i].name, "_valid"},  mem_to_wb_valid, 1);
      chk({vecs[i].name, "_pc"},     mem_pc, 32'h1c00_0000 + 32'(i * 4));
    end

    // Forwarding bus layout with CSR write
    @(negedge clk);
    exe_to_mem_valid = 1'b1; exe_mem_all = '0; exe_res_from_mem = 1'b0;
    exe_result = 32'h55; exe_rf_all = 6'b10_0101;
    exe_csr_rf = '0; exe_csr_rf[77] = 1'b1; exe_csr_rf[76:63] = 14'h0006;
    @(negedge clk);
    exe_to_mem_valid = 1'b0; exe_csr_rf = '0;
    #1;
    chk("fwd_layout", mem_fwd_all, {1'b1, 14'h0006, 1'b1, 5'd5, 32'h55});

    // Store behind a syscall sitting in MEM is suppressed, then flush
    @(negedge clk);
    exe_to_mem_valid = 1'b1; exe_mem_all = '0; exe_exc_rf = 2'b10; exe_rf_all = '0;
    @(negedge clk);
    exe_exc_rf = 2'b00; exe_mem_all = 8'b1000_0001; exe_result = 32'h80;
    exe_rkd_value = 32'h1; exe_rf_all = 6'b10_0011;
    #1;
    chk("kill_mem_exc", mem_exc_rf, 2'b10);
    chk("kill_en", data_sram_en, 0);
    chk("kill_we", data_sram_we, 0);
    @(negedge clk);
    exe_to_mem_valid = 1'b0; cancel_exc_ertn = 1'b1;
    @(negedge clk);
    cancel_exc_ertn = 1'b0;
    #1;
    chk("cancel_valid", mem_to_wb_valid, 0);
    chk("cancel_fwd_rfwe", mem_fwd_all[37], 0);
    chk("cancel_payload_held", mem_rf_all, 6'b10_0011);

    // WB exception pending suppresses a load; cancel on handoff drops it
    @(negedge clk);
    exe_to_mem_valid = 1'b1; exe_mem_all = 8'b0001_0000; exe_res_from_mem = 1'b1;
    exe_result = 32'h90; exe_rf_all = 6'b10_0010; wb_exc_pending = 1'b1;
    #1;
    chk("wbexc_en", data_sram_en, 0);
    @(negedge clk);
    wb_exc_pending = 1'b0; cancel_exc_ertn = 1'b1;
    #1;
    chk("cancel_handoff_en", data_sram_en, 0);
    @(negedge clk);
    cancel_exc_ertn = 1'b0; exe_to_mem_valid = 1'b0;
    #1;
    chk("cancel_handoff_valid", mem_to_wb_valid, 0);

    // WB stall: load result must hold while SRAM output turns to garbage
    @(negedge clk);
    base = req_cnt;
    exe_to_mem_valid = 1'b1; exe_mem_all = 8'b0001_0000; exe_res_from_mem = 1'b1;
    exe_result = 32'h10; exe_rf_all = 6'b10_0100;
    @(negedge clk);
    exe_result = 32'h20; wb_allowin = 1'b0; data_sram_rdata = 32'h1122_3344;
    #1;
    chk("stall_first", mem_result, 32'h1122_3344);
    chk("stall_allowin", mem_allowin, 0);
    chk("stall_no_req", data_sram_en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_sram_rdata = $urandom;
      #1;
      chk("stall_hold", mem_result, 32'h1122_3344);
    end
    chk("stall_req_count", req_cnt - base, 1);
    chk("stall_valid", mem_to_wb_valid, 1);
    @(negedge clk);
    exe_to_mem_valid = 1'b0; wb_allowin = 1'b1;

    // Reset in the middle of a load
    @(negedge clk);
    exe_to_mem_valid = 1'b1; exe_mem_all = 8'b0001_0000; exe_res_from_mem = 1'b1;
    exe_result = 32'h30; exe_rf_all = 6'b10_0111;
    @(negedge clk);
    exe_to_mem_valid = 1'b0; resetn = 1'b0; data_sram_rdata = 32'hA5A5_0001;
    base = req_cnt;
    @(negedge clk);
    #1;
    chk("midrst_valid", mem_to_wb_valid, 0);
    chk("midrst_fwd", mem_fwd_all, 0);
    chk("midrst_en", data_sram_en, 0);
    chk("midrst_req", req_cnt - base, 0);
    resetn = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
